writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage_pkg.sv | 16 +
 rtl/writeback_stage_select.sv | 37 +++
 rtl/writeback_stage.sv | 94 +++++++++
 tb/tb_writeback_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: source-select encodings and default widths.
package writeback_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int BYTE_W_DEF = 8;
  localparam int RG_W_DEF   = 4;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    SEL_MEM    = 2'd0,
    SEL_ALU    = 2'd1,
    SEL_BYTE_Z = 2'd2,
    SEL_BYTE_S = 2'd3
  } sel_e;

endpackage

// File: rtl/writeback_stage_select.sv
// Combinational 4:1 writeback source select with byte zero/sign extension.
module wb_select
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] do_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [BYTE_W-1:0] dob_in,
  output logic [DATA_W-1:0] data
);

  localparam int EXT_W = DATA_W - BYTE_W;

  logic [EXT_W-1:0] sign_ext;

  genvar gi;
  generate
    for (gi = 0; gi < EXT_W; gi++) begin : g_ext
      assign sign_ext[gi] = dob_in[BYTE_W-1];
    end
  endgenerate

  always_comb begin
    data = do_in;
    case (sel)
      SEL_MEM:    data = do_in;
      SEL_ALU:    data = alu_result;
      SEL_BYTE_Z: data = {{EXT_W{1'b0}}, dob_in};
      SEL_BYTE_S: data = {sign_ext, dob_in};
      default:    data = do_in;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Single-entry writeback pipeline register with valid/ready handshake,
// register-file write strobe (register 0 suppressed) and saturating commit counter.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF,
  parameter int RG_W   = RG_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] do_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [BYTE_W-1:0] dob_in,
  input  logic [RG_W-1:0]   rg_in,
  input  logic [1:0]        sel_dat,
  input  logic              wr_en_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [RG_W-1:0]   rg,
  output logic [BYTE_W-1:0] dob,
  output logic              rf_we,
  output logic [CNT_W-1:0]  commit_cnt
);

  logic              out_valid_reg;
  logic [DATA_W-1:0] wb_data_reg;
  logic [RG_W-1:0]   rg_reg;
  logic [BYTE_W-1:0] dob_reg;
  logic              wr_en_reg;
  logic [CNT_W-1:0]  commit_cnt_reg;
  logic [CNT_W-1:0]  commit_cnt_next;
  logic [DATA_W-1:0] sel_data;
  logic              in_fire;
  logic              out_fire;

  wb_select #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W)
  ) u_select (
    .sel        (sel_dat),
    .do_in      (do_in),
    .alu_result (alu_result),
    .dob_in     (dob_in),
    .data       (sel_data)
  );

  // The entry may be replaced in the same cycle it drains, so a stalled
  // consumer is the only thing that blocks upstream.
  assign in_ready = !out_valid_reg || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_reg && out_ready;
  assign rf_we    = out_fire && wr_en_reg && (rg_reg != '0);

  always_comb begin
    commit_cnt_next = commit_cnt_reg;
    if (rf_we && (commit_cnt_reg != '1)) begin
      commit_cnt_next = commit_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      wb_data_reg    <= '0;
      rg_reg         <= '0;
      dob_reg        <= '0;
      wr_en_reg      <= 1'b0;
      commit_cnt_reg <= '0;
    end else begin
      if (in_fire) begin
        out_valid_reg <= 1'b1;
        wb_data_reg   <= sel_data;
        rg_reg        <= rg_in;
        dob_reg       <= dob_in;
        wr_en_reg     <= wr_en_in;
      end else if (out_fire) begin
        out_valid_reg <= 1'b0;
      end
      commit_cnt_reg <= commit_cnt_next;
    end
  end

  assign out_valid  = out_valid_reg;
  assign wb_data    = wb_data_reg;
  assign rg         = rg_reg;
  assign dob        = dob_reg;
  assign commit_cnt = commit_cnt_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed plus randomized bench for writeback_stage against a queue-based reference model.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] do_in;
  logic [31:0] alu_result;
  logic [7:0]  dob_in;
  logic [3:0]  rg_in;
  logic [1:0]  sel_dat;
  logic        wr_en_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] wb_data;
  logic [3:0]  rg;
  logic [7:0]  dob;
  logic        rf_we;
  logic [15:0] commit_cnt;

  writeback_stage #(
    .DATA_W (32),
    .BYTE_W (8),
    .RG_W   (4),
    .CNT_W  (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .do_in      (do_in),
    .alu_result (alu_result),
    .dob_in     (dob_in),
    .rg_in      (rg_in),
    .sel_dat    (sel_dat),
    .wr_en_in   (wr_en_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .wb_data    (wb_data),
    .rg         (rg),
    .dob        (dob),
    .rf_we      (rf_we),
    .commit_cnt (commit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  rg;
    logic [7:0]  dob;
    logic        we;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] mcnt;
  int          checks = 0;
  int          errors = 0;
  bit          quiet  = 1'b0;
  logic [31:0] held_data;

  // Expected writeback value from the select rules, using plain arithmetic.
  function automatic logic [31:0] ref_data(logic [1:0] s, logic [31:0] m, logic [31:0] a, logic [7:0] b);
    int v;
    case (s)
      2'd0:    return m;
      2'd1:    return a;
      2'd2:    return 32'(b);
      default: begin
        v = int'(b);
        if (v >= 128) v = v - 256;
        return 32'(v);
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] m, input logic [31:0] a,
                       input logic [7:0] b, input logic [3:0] r, input logic we);
    in_valid   = v;
    sel_dat    = s;
    do_in      = m;
    alu_result = a;
    dob_in     = b;
    rg_in      = r;
    wr_en_in   = we;
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance the model at the edge.
  task automatic step();
    bit exp_valid, exp_we, in_fire, out_fire;
    @(negedge clk);
    exp_valid = (mq.size() != 0);
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    chk("in_ready", {31'd0, in_ready}, {31'd0, !exp_valid || out_ready});
    exp_we = 1'b0;
    if (exp_valid) begin
      chk("wb_data", wb_data, mq[0].data);
      chk("rg", {28'd0, rg}, {28'd0, mq[0].rg});
      chk("dob", {24'd0, dob}, {24'd0, mq[0].dob});
      exp_we = out_ready && mq[0].we && (mq[0].rg != 4'd0);
    end
    chk("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
    chk("commit_cnt", {16'd0, commit_cnt}, {16'd0, mcnt});
    in_fire  = in_valid && (!exp_valid || out_ready);
    out_fire = exp_valid && out_ready;
    @(posedge clk);
    if (out_fire) begin
      if (!quiet) $display("commit rg=%0d data=%h dob=%h we=%0d strobe=%0d", mq[0].rg, mq[0].data, mq[0].dob, mq[0].we, exp_we);
      if (exp_we && mcnt != 16'hFFFF) mcnt++;
      void'(mq.pop_front());
    end
    if (in_fire) mq.push_back('{ref_data(sel_dat, do_in, alu_result, dob_in), rg_in, dob_in, wr_en_in});
    #1;
  endtask

  initial begin
    mcnt      = 16'd0;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 2'd0, 32'd0, 32'd0, 8'd0, 4'd0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_cnt", {16'd0, commit_cnt}, 32'd0);
    rst_n = 1'b1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single ALU candidate
    out_ready = 1'b1;
    drive(1'b1, 2'd1, 32'h0, 32'h0000_1234, 8'h00, 4'd5, 1'b1);
    step();
    drive(1'b0, 2'd0, 32'hx, 32'hx, 8'hx, 4'hx, 1'bx);
    chk("alu_data", wb_data, 32'h0000_1234);
    chk("alu_rf_we", {31'd0, rf_we}, 32'd1);
    step();
    chk("alu_cnt", {16'd0, commit_cnt}, 32'd1);

    // Byte extension and memory word, back-to-back
    drive(1'b1, 2'd2, 32'h0, 32'h0, 8'h80, 4'd1, 1'b1);
    step();
    chk("byte_z", wb_data, 32'h0000_0080);
    drive(1'b1, 2'd3, 32'h0, 32'h0, 8'h80, 4'd2, 1'b1);
    step();
    chk("byte_s", wb_data, 32'hFFFF_FF80);
    drive(1'b1, 2'd0, 32'hDEAD_BEEF, 32'h0, 8'h11, 4'd3, 1'b1);
    step();
    chk("mem_word", wb_data, 32'hDEAD_BEEF);

    // Stall for 3 cycles with a new candidate waiting
    out_ready = 1'b0;
    drive(1'b1, 2'd1, 32'h0, 32'hCAFE_0001, 8'h22, 4'd7, 1'b1);
    step();
    held_data = wb_data;
    repeat (3) begin
      step();
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_hold", wb_data, held_data);
      chk("stall_rf_we", {31'd0, rf_we}, 32'd0);
    end
    out_ready = 1'b1;
    drive(1'b1, 2'd1, 32'h0, 32'hCAFE_0002, 8'h33, 4'd8, 1'b1);
    step();
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_data", wb_data, 32'hCAFE_0002);

    // rg=0 with write enable, rg=3 without: neither commits
    drive(1'b1, 2'd1, 32'h0, 32'h0000_00AA, 8'h00, 4'd0, 1'b1);
    step();
    drive(1'b1, 2'd1, 32'h0, 32'h0000_00BB, 8'h00, 4'd3, 1'b0);
    step();
    chk("rg0_rf_we", {31'd0, rf_we}, 32'd0);
    drive(1'b0, 2'd0, 32'hx, 32'hx, 8'hx, 4'hx, 1'bx);
    step();
    chk("nowe_rf_we", {31'd0, rf_we}, 32'd0);
    step();

    // Randomized traffic; unused fields are random while in_valid is low
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 1) == 1, 2'($urandom), $urandom, $urandom, 8'($urandom), 4'($urandom), 1'($urandom));
      step();
    end

    // Counter saturation
    quiet = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 70000 && mcnt != 16'hFFFE; i++) begin
      drive(1'b1, 2'd1, 32'h0, $urandom, 8'h00, 4'd1, 1'b1);
      step();
    end
    quiet = 1'b0;
    chk("fill_reached", {16'd0, mcnt}, 32'h0000_FFFE);
    // Drain the entry still held so exactly three commits follow
    drive(1'b0, 2'd0, 32'h0, 32'h0, 8'h00, 4'd0, 1'b0);
    step();
    repeat (3) begin
      drive(1'b1, 2'd1, 32'h0, 32'h0000_5555, 8'h00, 4'd6, 1'b1);
      step();
    end
    drive(1'b0, 2'd0, 32'h0, 32'h0, 8'h00, 4'd0, 1'b0);
    step();
    step();
    chk("sat_cnt", {16'd0, commit_cnt}, 32'h0000_FFFF);

    // Asynchronous reset while an entry is stalled
    out_ready = 1'b0;
    drive(1'b1, 2'd1, 32'h0, 32'h0000_7777, 8'h44, 4'd9, 1'b1);
    step();
    drive(1'b0, 2'd0, 32'h0, 32'h0, 8'h00, 4'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_data", wb_data, 32'd0);
    chk("arst_rg", {28'd0, rg}, 32'd0);
    chk("arst_dob", {24'd0, dob}, 32'd0);
    chk("arst_cnt", {16'd0, commit_cnt}, 32'd0);
    chk("arst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    mq.delete();
    mcnt = 16'd0;
    @(posedge clk);
    #1;
    chk("arst_hold_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 2'd2, 32'h0, 32'h0, 8'h5A, 4'd4, 1'b1);
    step();
    chk("after_rst_data", wb_data, 32'h0000_005A);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 8'h00, 4'd0, 1'b0);
    step();
    step();
    chk("after_rst_cnt", {16'd0, commit_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
